// File: rtl/gray_cnt.sv
// Up/down Gray-code counter with registered Gray and binary outputs plus a wrap pulse.
// Optional `GRAY_CNT_CHK_EN adds a sticky err flag that watches for multi-bit Gray steps.
module gray_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
`ifdef GRAY_CNT_CHK_EN
  output logic             err,
`endif
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;
  logic             step;

  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    step   = 1'b0;
    if (load) begin
      b_d = load_val;
    end else if (en) begin
      step = 1'b1;
      if (up_dn) begin
        b_d    = b_q + 1'b1;
        wrap_d = (b_q == ONES);
      end else begin
        b_d    = b_q - 1'b1;
        wrap_d = (b_q == '0);
      end
    end
    // Gray is derived from next-state binary so g and b land on the same edge.
    g_d = b_d ^ (b_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign g    = g_q;
  assign b    = b_q;
  assign wrap = wrap_q;

`ifdef GRAY_CNT_CHK_EN
  // Check runs one edge behind the step it judges: g_prev_q/step_q capture that step.
  logic [WIDTH-1:0] g_prev_q;
  logic [WIDTH-1:0] g_diff;
  logic             armed_q, step_q, err_q, err_d;

  always_comb begin
    g_diff = g_q ^ g_prev_q;
    err_d  = err_q;
    if (step_q && ((g_diff == '0) || ((g_diff & (g_diff - 1'b1)) != '0)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev_q <= '0;
      armed_q  <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      g_prev_q <= g_q;
      armed_q  <= 1'b1;
      step_q   <= armed_q & step;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_cnt.sv
// Self-checking bench for gray_cnt: arithmetic reference model, per-cycle compare, directed pins.
module tb_gray_cnt;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] g, b;
  logic         wrap;
`ifdef GRAY_CNT_CHK_EN
  logic         err;
`endif

  gray_cnt #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .g(g), .b(b),
`ifdef GRAY_CNT_CHK_EN
    .err(err),
`endif
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain modular arithmetic on an integer count.
  int m_b    = 0;
  int m_wrap = 0;
  int m_step = 0;
  bit cmp_on = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b = 0; m_wrap = 0; m_step = 0;
    end else if (load) begin
      m_b = int'(load_val); m_wrap = 0; m_step = 0;
    end else if (en) begin
      m_step = 1;
      if (up_dn) begin
        m_wrap = (m_b == MOD - 1) ? 1 : 0;
        m_b    = (m_b + 1) % MOD;
      end else begin
        m_wrap = (m_b == 0) ? 1 : 0;
        m_b    = (m_b + MOD - 1) % MOD;
      end
    end else begin
      m_wrap = 0; m_step = 0;
    end
  end

  function automatic int to_gray(int v);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, on the falling edge.
  logic [W-1:0] g_last = '0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_b", int'(b), m_b);
      chk("cyc_g", int'(g), to_gray(m_b));
      chk("cyc_wrap", int'(wrap), m_wrap);
      if (m_step != 0 && rst_n) chk("cyc_onebit", $countones(g ^ g_last), 1);
    end
    g_last = g;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(bit l, bit e, bit u, int v);
    load = l; en = e; up_dn = u; load_val = W'(v);
  endtask

  int up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                      4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_g", int'(g), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_wrap", int'(wrap), 0);

    // Down wrap from 0.
    drive(0, 1, 0, 0); tick();
    chk("dn_b", int'(b), 15); chk("dn_g", int'(g), 4'b1000); chk("dn_wrap", int'(wrap), 1);
    tick();
    chk("dn2_b", int'(b), 14); chk("dn2_g", int'(g), 4'b1001); chk("dn2_wrap", int'(wrap), 0);

    // Loading 0 never wraps; then 16 up steps against the literal Gray table.
    drive(1, 1, 0, 0); tick();
    chk("ld0_wrap", int'(wrap), 0); chk("ld0_b", int'(b), 0);
    drive(0, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("up_g", int'(g), up_seq[i]);
      chk("up_b", int'(b), (i + 1) % 16);
      chk("up_wrap", int'(wrap), (i == 15) ? 1 : 0);
    end

    // Load beats en; all-ones load does not wrap.
    drive(1, 1, 1, 15); tick();
    chk("ldones_wrap", int'(wrap), 0);
    drive(1, 1, 1, 9); tick();
    chk("ld_b", int'(b), 9); chk("ld_g", int'(g), 4'b1101); chk("ld_wrap", int'(wrap), 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_g", int'(g), 4'b1101); chk("hold_b", int'(b), 9);
    end

    // Direction change at b=5.
    drive(1, 0, 0, 3); tick();
    drive(0, 1, 1, 0); tick(); tick();
    chk("dir_b5", int'(b), 5); chk("dir_g5", int'(g), 4'b0111);
    up_dn = 1'b0; tick();
    chk("dir_b4", int'(b), 4); chk("dir_g4", int'(g), 4'b0110);

    // Async reset mid-count, observed before any clock edge.
    drive(1, 0, 0, 6); tick();
    drive(0, 1, 1, 0); #1;
    rst_n = 1'b0; #1;
    chk("arst_g", int'(g), 0); chk("arst_b", int'(b), 0); chk("arst_wrap", int'(wrap), 0);
    tick();
    drive(0, 0, 1, 0); rst_n = 1'b1;
    tick(); tick();
    chk("rel_g", int'(g), 0); chk("rel_b", int'(b), 0);

    // Randomized traffic with occasional loads and resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(9) == 0), ($urandom_range(3) != 0), $urandom_range(1), $urandom_range(MOD - 1));
      if (i % 16 == 0) begin
        if ($urandom_range(2) == 0) load_val = ($urandom_range(1) != 0) ? W'(MOD - 1) : '0;
        else if ($urandom_range(3) == 0) load_val = W'(MOD - 2);
      end
      if ($urandom_range(60) == 0) begin
        #1; rst_n = 1'b0; #1;
        chk("rnd_arst_b", int'(b), 0);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

`ifdef GRAY_CNT_CHK_EN
    chk("err_clean", int'(err), 0);
    drive(1, 0, 0, 4); tick();
    drive(0, 1, 1, 0); tick(); tick();
    cmp_on = 1'b0;
    force dut.g_q = g ^ W'(3);
    tick(); tick();
    release dut.g_q;
    drive(1, 0, 0, 0); tick(); tick();
    chk("err_set", int'(err), 1);
    drive(0, 0, 0, 0); tick(); tick();
    chk("err_sticky", int'(err), 1);
    rst_n = 1'b0; #1;
    chk("err_rst", int'(err), 0);
    tick(); rst_n = 1'b1; tick();
    cmp_on = 1'b1;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end
endmodule
